inttofloat_arbiter: RTL and testbench

//  Shares one inttofloat converter between NUM_REQ requesters (e.g. per-voice

---
 rtl/inttofloat_arbiter_pkg.sv | 29 ++
 rtl/inttofloat_arbiter_rr_arbiter.sv | 32 +++
 rtl/inttofloat_arbiter.sv | 132 +++++++++++++
 tb/tb_inttofloat_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inttofloat_arbiter_pkg.sv
// Shared definitions for the converter arbiter: FSM encodings, the float
// zero returned on an aborted conversion, and small index helpers.
package inttofloat_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  // Timeout counter width; TIMEOUT is limited to 1..255.
  localparam int CNT_W = 8;

  // (base + off) mod n, for base < n and off < n.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

  // idx + 1 mod n.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    return wrap_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/inttofloat_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the
// pointer, wrapping at NUM_REQ-1 -> 0. Reusable by other shared-unit
// schedulers.
module rr_arbiter
  import inttofloat_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   pointer,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the pointer outward; the first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'(wrap_add(32'(pointer), off, NUM_REQ));
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/inttofloat_arbiter.sv
// Shares one inttofloat converter between NUM_REQ requesters. Round-robin
// grant, one-cycle load pulse to the converter, then waits for done (or a
// timeout) and returns the float with a one-cycle ack to the winner.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | pick a winner among req & ~ack, latch its index and data
//  LOAD    | cvt_start high for this single cycle, timeout counter cleared
//  WAIT    | watch cvt_done; ack with result, or abort with err on timeout
//
// Latency counted in clock edges from the grant edge: ack lands three edges
// later for a nonzero input, two for zero (the converter finishes zero in the
// load cycle). With other requesters pending the next grant follows the ack
// edge directly, so conversions stream every four cycles; the requester just
// acked is masked for one cycle while it drops req.
module inttofloat_arbiter
  import inttofloat_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             result,
  output logic                    err,
  output logic                    busy,
  output logic                    cvt_start,
  output logic [15:0]             cvt_intin,
  input  logic [31:0]             cvt_floatout,
  input  logic                    cvt_done
);

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   tcnt;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [15:0]        sel_data;
  logic [NUM_REQ-1:0] idx_onehot;
  logic [IDX_W-1:0]   ptr_next;
  logic               timed_out;

  // The requester being acked this cycle may still hold req; keep it out.
  assign eligible = req & ~ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible    (eligible),
    .pointer     (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Select the winning requester's 16-bit operand.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) sel_data = req_data[16*i +: 16];
    end
  end

  assign idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  assign ptr_next   = IDX_W'(wrap_inc(32'(idx), NUM_REQ));
  assign timed_out  = (tcnt == CNT_W'(TIMEOUT - 1));

  // Sequencer: grant, load pulse, wait for done or timeout, ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      idx       <= '0;
      tcnt      <= '0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cvt_start <= 1'b0;
      cvt_intin <= '0;
      result    <= FLOAT_ZERO;
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      cvt_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            idx       <= grant_idx;
            cvt_intin <= sel_data;
            cvt_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        // cvt_done may still be high from the previous conversion here.
        ST_LOAD: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cvt_done) begin
            result <= cvt_floatout;
            ack    <= idx_onehot;
            ptr    <= ptr_next;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (timed_out) begin
            result <= FLOAT_ZERO;
            ack    <= idx_onehot;
            err    <= 1'b1;
            ptr    <= ptr_next;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inttofloat_arbiter.sv
// Bench for inttofloat_arbiter with a behavioural inttofloat converter on the
// cvt_* ports. Converter timing: on a load edge a zero input completes at
// once; a nonzero input raises done one edge later. done stays high until the
// next load, so a stale done is visible during the following LOAD cycle.
module tb_inttofloat_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  ack;
  logic [31:0] result;
  logic        err;
  logic        busy;
  logic        cvt_start;
  logic [15:0] cvt_intin;
  logic [31:0] cvt_floatout;
  logic        cvt_done;

  logic [31:0] conv_out = '0;
  logic [31:0] conv_stage = '0;
  logic        conv_done_q = 1'b0;
  logic        conv_pend = 1'b0;
  logic        kill_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = 0;

  inttofloat_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .result       (result),
    .err          (err),
    .busy         (busy),
    .cvt_start    (cvt_start),
    .cvt_intin    (cvt_intin),
    .cvt_floatout (cvt_floatout),
    .cvt_done     (cvt_done)
  );

  always #5 clk = ~clk;

  // Converter model: conversion via the simulator's real arithmetic.
  function automatic logic [31:0] conv_real(input logic [15:0] v);
    logic [63:0] b;
    int iv;
    int e;
    iv = int'($signed(v));
    b  = $realtobits($itor(iv));
    e  = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  always @(posedge clk) begin
    if (cvt_start) begin
      if (cvt_intin == 16'd0) begin
        conv_out    <= 32'd0;
        conv_done_q <= 1'b1;
        conv_pend   <= 1'b0;
      end else begin
        conv_stage  <= conv_real(cvt_intin);
        conv_done_q <= 1'b0;
        conv_pend   <= 1'b1;
      end
    end else if (conv_pend) begin
      conv_out    <= conv_stage;
      conv_done_q <= 1'b1;
      conv_pend   <= 1'b0;
    end
  end

  assign cvt_floatout = conv_out;
  assign cvt_done     = conv_done_q & ~kill_done;

  // Reference: IEEE single from a 16-bit signed integer, by leading-one search.
  function automatic logic [31:0] ref_float(input logic [15:0] v);
    int val;
    int mag;
    int p;
    logic [31:0] f;
    val = int'($signed(v));
    if (val == 0) return 32'd0;
    mag = (val < 0) ? -val : val;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    f[31]    = (val < 0);
    f[30:23] = 8'(127 + p);
    f[22:0]  = 23'((mag - (1 << p)) << (23 - p));
    return f;
  endfunction

  // Waits up to limit negedges for an ack; lat = -1 if none arrived.
  task automatic wait_ack(input int limit, output logic [3:0] a,
                          output logic [31:0] r, output logic e, output int lat);
    a = '0; r = '0; e = 1'b0; lat = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        a = ack; r = result; e = err; lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0 || cvt_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack=%b err=%b busy=%b cvt_start=%b, want all 0", ack, err, busy, cvt_start);
    end
    n_checks++;
    if (result !== 32'h0 || cvt_intin !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h cvt_intin=%h, want 0/0", result, cvt_intin);
    end
    reset = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    req_data[15:0] = 16'd1;
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (cvt_start !== 1'b1 || cvt_intin !== 16'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_pulse: cvt_start=%b cvt_intin=%h busy=%b, want 1/0001/1", cvt_start, cvt_intin, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cvt_start !== 1'b0) begin
      n_fail++;
      $display("FAIL load_one_cycle: cvt_start=%b, want 0", cvt_start);
    end
    wait_ack(60, a, r, e, lat);
    if (lat >= 0) lat += 2;
    n_checks++;
    if (a !== 4'b0001 || r !== 32'h3F80_0000 || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL single_one: ack=%b result=%h err=%b lat=%0d, want 0001/3f800000/0/4", a, r, e, lat);
    end
    req = 4'b0000;
    mptr = 1;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse: ack=%b busy=%b, want 0000/0", ack, busy);
    end
  endtask

  task automatic test_neg_zero();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    req_data[15:0] = 16'hFFFE;
    req = 4'b0001;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0001 || r !== 32'hC000_0000 || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL neg_two: ack=%b result=%h err=%b lat=%0d, want 0001/c0000000/0/4", a, r, e, lat);
    end
    req = 4'b0000;
    @(negedge clk);
    req_data[15:0] = 16'd0;
    req = 4'b0001;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0001 || r !== 32'h0000_0000 || e !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL zero_input: ack=%b result=%h err=%b lat=%0d, want 0001/00000000/0/3", a, r, e, lat);
    end
    req = 4'b0000;
    mptr = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    logic [31:0] exp_r [4];
    exp_r = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    do_reset();
    req_data = {16'd4, 16'd3, 16'd2, 16'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(60, a, r, e, lat);
      n_checks++;
      if (a !== (4'b0001 << (k % 4)) || r !== exp_r[k % 4] || e !== 1'b0 || lat != 4) begin
        n_fail++;
        $display("FAIL rr_seq%0d: ack=%b result=%h err=%b lat=%0d, want %b/%h/0/4",
                 k, a, r, e, lat, 4'b0001 << (k % 4), exp_r[k % 4]);
      end
    end
    req = 4'b0000;
    mptr = 1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    logic seen;
    req_data[31:16] = 16'd2;
    req = 4'b0010;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0010 || r !== 32'h4000_0000 || lat != 4) begin
      n_fail++;
      $display("FAIL serve_one: ack=%b result=%h lat=%0d, want 0010/40000000/4", a, r, lat);
    end
    // req1 still high through its ack cycle: must not be granted again.
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_mask: busy=%b, want 0", busy);
    end
    req = 4'b0000;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 4'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_reserve: spurious ack seen=%b, want 0", seen);
    end
    mptr = 2;
    req_data[15:0]  = 16'd1;
    req_data[31:16] = 16'd4;
    req = 4'b0011;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0001 || r !== 32'h3F80_0000 || lat != 4) begin
      n_fail++;
      $display("FAIL wrap_first: ack=%b result=%h lat=%0d, want 0001/3f800000/4", a, r, lat);
    end
    req = 4'b0010;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0010 || r !== 32'h4080_0000 || lat != 4) begin
      n_fail++;
      $display("FAIL wrap_second: ack=%b result=%h lat=%0d, want 0010/40800000/4", a, r, lat);
    end
    req = 4'b0000;
    mptr = 2;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    logic seen;
    req_data[47:32] = 16'd5;
    req = 4'b0100;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || ack !== 4'b0 || cvt_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b ack=%b cvt_start=%b, want 0/0000/0", busy, ack, cvt_start);
    end
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 4'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_ack: ack seen=%b, want 0", seen);
    end
    req_data[31:16] = 16'd3;
    req_data[47:32] = 16'd5;
    req = 4'b0110;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0010 || r !== 32'h4040_0000 || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL post_reset1: ack=%b result=%h err=%b lat=%0d, want 0010/40400000/0/4", a, r, e, lat);
    end
    req = 4'b0100;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b0100 || r !== 32'h40A0_0000 || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL post_reset2: ack=%b result=%h err=%b lat=%0d, want 0100/40a00000/0/4", a, r, e, lat);
    end
    req = 4'b0000;
    mptr = 3;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0] a; logic [31:0] r; logic e; int lat;
    kill_done = 1'b1;
    req_data[63:48] = 16'd7;
    req = 4'b1000;
    wait_ack(60, a, r, e, lat);
    n_checks++;
    if (a !== 4'b1000 || e !== 1'b1 || r !== 32'h0 || lat != TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL timeout_abort: ack=%b err=%b result=%h lat=%0d, want 1000/1/00000000/%0d",
               a, e, r, lat, TIMEOUT + 2);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: err=%b busy=%b ack=%b, want 0/0/0000", err, busy, ack);
    end
    kill_done = 1'b0;
    mptr = 0;
  endtask

  task automatic test_random();
    logic [3:0]  mask;
    logic [15:0] d [4];
    int          order [$];
    int          k;
    int          lat;
    logic [3:0]  a;
    logic [31:0] r;
    logic        e;
    for (int rnd = 0; rnd < 24; rnd++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        d[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        req_data[16*i +: 16] = d[i];
      end
      order.delete();
      for (int off = 0; off < 4; off++) begin
        if (mask[(mptr + off) % 4]) order.push_back((mptr + off) % 4);
      end
      req = mask;
      foreach (order[j]) begin
        k = order[j];
        a = '0; r = '0; e = 1'b0; lat = -1;
        for (int c = 1; c <= 60; c++) begin
          @(negedge clk);
          if (c == 1) req_data[16*k +: 16] = 16'($urandom);
          if (ack != 4'b0) begin
            a = ack; r = result; e = err; lat = c;
            break;
          end
        end
        n_checks++;
        if (a !== (4'b0001 << k) || r !== ref_float(d[k]) || e !== 1'b0 ||
            lat != ((d[k] == 16'd0) ? 3 : 4)) begin
          n_fail++;
          $display("FAIL rand%0d_req%0d: ack=%b result=%h err=%b lat=%0d, want %b/%h/0/%0d (data %h)",
                   rnd, k, a, r, e, lat, 4'b0001 << k, ref_float(d[k]),
                   (d[k] == 16'd0) ? 3 : 4, d[k]);
        end
        req[k] = 1'b0;
        mptr = (k + 1) % 4;
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || ack !== 4'b0) begin
        n_fail++;
        $display("FAIL rand%0d_idle: busy=%b ack=%b, want 0/0000", rnd, busy, ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_neg_zero();
    test_back_to_back();
    test_pointer_wrap();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
